ksa_swap_loop: RTL
==================

Name: ksa_swap_loop

Overview:
Worker for the second loop of the RC4 key-scheduling phase. It takes the second_loop_start level from the loop sequencer and runs the 256-iteration pass j = j + S[i] + key[i mod KEY_LEN], swapping S[i] and S[j]. It returns second_loop_done to the sequencer. It sits between the sequencer and the 256x8 S-memory, which is single-port, synchronous, and has 1-cycle read latency.

Parameters:
KEY_LEN, 3, number of secret key bytes
ADDR_W, 8, S-memory address width (256 entries)
DATA_W, 8, S-memory word width

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  level request from the loop sequencer (second_loop_start)
secret_key  in  8*KEY_LEN  key; byte 0 = secret_key[8*KEY_LEN-1 -: 8] (MSB first)
done  out  1  loop complete (second_loop_done)
busy  out  1  high while an iteration pass is in progress
mem_addr  out  ADDR_W  S-memory address
mem_data  out  DATA_W  S-memory write data
mem_wren  out  1  S-memory write enable
mem_q  in  DATA_W  S-memory read data; valid in the cycle after its address is presented

Behaviour:
- Reset: rst is asynchronous, active-high. While rst is high:
  - state = IDLE
  - done = 0, busy = 0, mem_wren = 0, mem_addr = 0, mem_data = 0
  - i = 0, j = 0, kidx = 0
- Start detection:
  - A registered copy of start, start_q, is kept. A launch occurs when start = 1 and start_q = 0 while in IDLE.
  - start held high from reset counts as a rising edge, because start_q resets to 0.
  - Start edges outside IDLE are ignored.
- mem_addr, mem_data and mem_wren are decoded combinationally from the state, i, j, si and sj registers.
- States, 6 cycles per iteration:
  - IDLE: busy = 0. On a launch, set i = 0, j = 0, kidx = 0 and go to RD_SI.
  - RD_SI: addr = i, wren = 0. Go to LAT_SI.
  - LAT_SI: si <= mem_q; j <= j + mem_q + key[kidx], mod 256 (8-bit wrap). Go to RD_SJ.
  - RD_SJ: addr = j (the updated value). Go to LAT_SJ.
  - LAT_SJ: sj <= mem_q. Go to WR_I.
  - WR_I: addr = i, data = sj, wren = 1. Go to WR_J.
  - WR_J: addr = j, data = si, wren = 1.
    - If i == 255: go to DONE.
    - Otherwise: i <= i + 1; kidx <= (kidx == KEY_LEN-1) ? 0 : kidx + 1; go to RD_SI.
  - DONE: done = 1, busy = 0, wren = 0. Stay in DONE while start = 1. When start = 0, go to IDLE and deassert done the next cycle.
- busy = 1 in every state from RD_SI through WR_J.
- Latency: done rises 256*6 = 1536 cycles after the first RD_SI cycle, which is 1537 cycles after the clock edge that samples the launch.
- kidx is a modulo counter; no divider is used.
- i == j: both writes hit the same address with equal data (si == sj). No special case is needed.
- j wrap: 8-bit overflow is discarded.
- Dropping start mid-pass is ignored. The pass completes, then DONE falls through to IDLE after 1 cycle, giving a 1-cycle done pulse.
- rst mid-pass aborts immediately. mem_wren drops asynchronously, S contents are left partially swapped, and done = 0.
- Exactly one memory write per cycle in WR_I and WR_J; there are no other writes.

Decomposition:
- Shared package rc4_pkg:
  - S_DEPTH = 256
  - ADDR_W and DATA_W defaults
  - key byte-select function key_byte(key, idx)
  - enum type ksa_state_t {IDLE, RD_SI, LAT_SI, RD_SJ, LAT_SJ, WR_I, WR_J, DONE}
- No sub-module. The FSM and datapath are small enough for one module. The start edge detector is inline.

Test Plan:
- Identity S (S[k] = k), key 0x000000, start high from reset:
  - iteration i=2 ends with S[2] = 3, S[3] = 2 and j = 3
  - i=0 and i=1 produce self-swaps with unchanged values
- Identity S, key 0x000249:
  - after i=0, j = 0
  - after i=1, j = 3, S[1] = 3, S[3] = 1
  - done rises exactly 1537 cycles after the launch-sampling edge
- Full pass vs. golden RC4 KSA model (key 0x000249, identity initial S):
  - all 256 S entries match
  - final S is a permutation (each 0..255 appears once)
- start held high after completion:
  - done stays 1 and no further writes occur
  - start low → done = 0 one cycle later
  - start re-raised → second pass begins from i = 0, j = 0
- Assert rst at cycle 500 of a pass:
  - mem_wren = 0 and done = 0 immediately
  - after release with start high, the pass restarts from i = 0
- Drop start at cycle 100 of a pass:
  - pass runs to completion
  - done is a single-cycle pulse at cycle 1537
  - FSM returns to IDLE

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: memory geometry, KSA swap-loop states,
// and key byte selection.
package rc4_pkg;

  localparam int S_DEPTH     = 256;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int KEY_LEN_DEF = 3;
  localparam int KEY_MAX     = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_SI,
    LAT_SI,
    RD_SJ,
    LAT_SJ,
    WR_I,
    WR_J,
    DONE
  } ksa_state_t;

  // Byte 0 is the most significant byte of the nbytes-wide key.
  function automatic logic [7:0] key_byte(
    input logic [8*KEY_MAX-1:0] key,
    input int unsigned          nbytes,
    input int unsigned          idx
  );
    logic [8*KEY_MAX-1:0] sh;
    sh = key >> (8 * (nbytes - 1 - idx));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/ksa_swap_loop.sv
// RC4 KSA second loop: j += S[i] + key[i mod KEY_LEN], swap S[i]/S[j]
// over a single-port S-memory with 1-cycle read latency.
module ksa_swap_loop
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = KEY_LEN_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] secret_key,
  output logic                 done,
  output logic                 busy,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_data,
  output logic                 mem_wren,
  input  logic [DATA_W-1:0]    mem_q
);

  localparam int KIDX_W =
    (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST =
    KIDX_W'(KEY_LEN - 1);
  localparam logic [ADDR_W-1:0] I_LAST = '1;

  ksa_state_t state;
  ksa_state_t state_nxt;

  logic                 start_q;
  logic                 launch;
  logic [ADDR_W-1:0]    i;
  logic [ADDR_W-1:0]    j;
  logic [KIDX_W-1:0]    kidx;
  logic [DATA_W-1:0]    si;
  logic [DATA_W-1:0]    sj;
  logic [8*KEY_MAX-1:0] key_ext;
  logic [7:0]           kb;

  assign launch  = start & ~start_q;
  assign key_ext = (8*KEY_MAX)'(secret_key);
  assign kb      = key_byte(key_ext, KEY_LEN, 32'(kidx));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (launch) state_nxt = RD_SI;
      RD_SI:   state_nxt = LAT_SI;
      LAT_SI:  state_nxt = RD_SJ;
      RD_SJ:   state_nxt = LAT_SJ;
      LAT_SJ:  state_nxt = WR_I;
      WR_I:    state_nxt = WR_J;
      WR_J:    state_nxt = (i == I_LAST) ? DONE : RD_SI;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done lags the DONE state by one cycle, so it also drops one
  // cycle after the FSM falls back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      done    <= 1'b0;
      i       <= '0;
      j       <= '0;
      kidx    <= '0;
      si      <= '0;
      sj      <= '0;
    end else begin
      start_q <= start;
      done    <= (state == DONE);
      case (state)
        IDLE: begin
          if (launch) begin
            i    <= '0;
            j    <= '0;
            kidx <= '0;
          end
        end
        LAT_SI: begin
          si <= mem_q;
          j  <= j + ADDR_W'(mem_q) + ADDR_W'(kb);
        end
        LAT_SJ: begin
          sj <= mem_q;
        end
        WR_J: begin
          if (i != I_LAST) begin
            i    <= i + ADDR_W'(1);
            kidx <= (kidx == KIDX_LAST) ? '0
                  : kidx + KIDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    unique case (1'b1)
      (state == RD_SI): begin
        busy     = 1'b1;
        mem_addr = i;
      end
      (state == LAT_SI): begin
        busy = 1'b1;
      end
      (state == RD_SJ): begin
        busy     = 1'b1;
        mem_addr = j;
      end
      (state == LAT_SJ): begin
        busy = 1'b1;
      end
      (state == WR_I): begin
        busy     = 1'b1;
        mem_addr = i;
        mem_data = sj;
        mem_wren = 1'b1;
      end
      (state == WR_J): begin
        busy     = 1'b1;
        mem_addr = j;
        mem_data = si;
        mem_wren = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
